mips_instr_encoder: RTL and testbench
=====================================

Name: mips_instr_encoder

Overview:
Converts symbolic instruction requests into 32-bit MIPS instruction words for the single-cycle core's instruction memory. It produces exactly the subset the core's control decoder accepts: add, sub, and, or, slt, lw, sw, beq, bne and j. Requests enter through a valid/ready handshake and are encoded in one registered stage. Encoded words are buffered in a small FIFO and drained to the instruction-memory write port with an auto-incrementing word address.

Parameters:
DEPTH, 4, FIFO entries; power of 2, at least 2.
ADDR_W, 32, width of the instruction-memory byte address.
BASE_ADDR, 0, byte address of the first word written after reset or clear; must be a multiple of 4.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
clear  in  1  synchronous flush; restarts addressing at BASE_ADDR.
in_valid  in  1  request valid.
in_ready  out  1  encoder can accept a request this cycle.
op_sel  in  4  0=ADD, 1=SUB, 2=AND, 3=OR, 4=SLT, 5=LW, 6=SW, 7=BEQ, 8=BNE, 9=J; 10-15 are illegal.
rs  in  5  source register.
rt  in  5  second source register, or load/store/branch target register.
rd  in  5  destination register (R-type only).
imm  in  16  immediate or offset (LW/SW/BEQ/BNE).
target  in  26  jump word target (J).
out_valid  out  1  imem_wdata/imem_addr valid.
out_ready  in  1  instruction memory accepts the word.
imem_wdata  out  32  encoded instruction (FIFO head).
imem_addr  out  ADDR_W  byte address for the head word.
word_count  out  16  words delivered since reset/clear; saturates at 0xFFFF.
err  out  1  sticky: an illegal op_sel was accepted.

Behaviour:
- Reset (async): FIFO empty, out_valid=0, imem_wdata=0, imem_addr=BASE_ADDR, word_count=0, err=0.
- Handshake rules:
  - in_ready = !full. It is combinational from FIFO occupancy and never depends on in_valid.
  - A request is accepted when in_valid && in_ready.
  - Input fields are sampled only on acceptance.
- Encoding:
  - R-type: opcode 000000, rs[25:21], rt[20:16], rd[15:11], shamt=0.
  - R-type funct: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A.
  - I-type: opcode, rs[25:21], rt[20:16], imm[15:0], copied verbatim with no sign handling. LW opcode 0x23, SW 0x2B, BEQ 0x04, BNE 0x05.
  - J: opcode 0x02, target[25:0].
  - rd is ignored for I/J types; rs/rt/imm are ignored for J.
- Illegal op_sel: the request is consumed (handshake completes), nothing is pushed, and err is set to 1 on the following edge.
- Latency: a legal word accepted at edge N is at the FIFO head, with out_valid=1, after edge N if the FIFO was empty. Otherwise it appears in order behind earlier words.
- Output side:
  - A transfer occurs on out_valid && out_ready.
  - On a transfer, the FIFO pops, imem_addr += 4 (modulo 2^ADDR_W, wrapping to 0), and word_count += 1 (saturating).
  - imem_wdata and imem_addr are stable while out_valid && !out_ready.
  - When empty, out_valid=0 and imem_wdata holds its last value.
- Push and pop in the same cycle are both performed, occupancy is unchanged, and pointers wrap modulo DEPTH.
- Full FIFO: in_ready=0. A pop in a cycle where the FIFO is full does not raise in_ready until the next cycle (no same-cycle pass-through).
- clear:
  - Highest priority over push/pop in the same cycle.
  - Empties the FIFO (pending words are discarded, not written).
  - imem_addr=BASE_ADDR, word_count=0, err=0.
  - Any input or output handshake in that cycle is ignored.
- Reset asserted mid-stream: immediate return to reset state; no partial word is ever presented.

Test Plan:
- ADD rs=1 rt=2 rd=3 into an empty FIFO, out_ready=1 -> next cycle out_valid=1, imem_wdata=0x00221820, imem_addr=0x0; after transfer, imem_addr=0x4, word_count=1.
- Sequence LW rs=29 rt=8 imm=0x0004; SLT rs=9 rt=8 rd=10; BEQ rs=4 rt=5 imm=0xFFFF; J target=0x10 -> words 0x8FA80004, 0x0128502A, 0x1085FFFF, 0x08000010, in order at addresses 0x0, 0x4, 0x8, 0xC.
- out_ready=0 while pushing 5 legal requests with DEPTH=4 -> in_ready=0 after the 4th acceptance; the 5th is held. Raise out_ready -> all 5 words delivered in order; head stays stable during stall.
- op_sel=12 with in_valid=1 -> in_ready=1, no out_valid, err=1 next cycle; subsequent legal requests still encode normally; clear -> err=0.
- 3 words queued and out_ready=0, then clear asserted together with in_valid -> FIFO empty, out_valid=0, imem_addr=BASE_ADDR, word_count=0, and the concurrent request is not captured.
- ADDR_W=4 with 5 words transferred -> imem_addr sequence 0x0, 0x4, 0x8, 0xC, 0x0 (wrap); async reset mid-burst -> out_valid drops immediately and all outputs return to reset values.

Source files
------------

// File: rtl/mips_instr_encoder.sv
// ---------------------------------------------------------------------------
// mips_instr_encoder
//   Turns symbolic instruction requests (add, sub, and, or, slt, lw, sw, beq,
//   bne, j) into 32-bit MIPS words. The words are queued in a small FIFO and
//   written to instruction memory at an auto-incrementing byte address.
//
// Ports
//   clk, reset        : rising-edge clock, asynchronous active-high reset
//   clear             : synchronous flush, restarts addressing at BASE_ADDR
//   in_valid/in_ready : request handshake (in_ready = FIFO not full)
//   op_sel, rs, rt, rd, imm, target : request fields, sampled on acceptance
//   out_valid/out_ready : instruction-memory write handshake
//   imem_wdata        : word at the FIFO head (holds last value when empty)
//   imem_addr         : byte address of the head word
//   word_count        : words delivered since reset/clear, saturating
//   err               : sticky flag, an illegal op_sel was accepted
// ---------------------------------------------------------------------------
module mips_instr_encoder #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       word_count,
  output logic              err
);

  localparam int                PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4'd4);

  // Returns {legal, word}; illegal selectors give legal=0 and a zero word.
  function automatic logic [32:0] encode(
    input logic [3:0]  op,
    input logic [4:0]  f_rs,
    input logic [4:0]  f_rt,
    input logic [4:0]  f_rd,
    input logic [15:0] f_imm,
    input logic [25:0] f_target
  );
    logic [32:0] res;
    case (op)
      4'd0:    res = {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h20};
      4'd1:    res = {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h22};
      4'd2:    res = {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h24};
      4'd3:    res = {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h25};
      4'd4:    res = {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h2A};
      4'd5:    res = {1'b1, 6'h23, f_rs, f_rt, f_imm};
      4'd6:    res = {1'b1, 6'h2B, f_rs, f_rt, f_imm};
      4'd7:    res = {1'b1, 6'h04, f_rs, f_rt, f_imm};
      4'd8:    res = {1'b1, 6'h05, f_rs, f_rt, f_imm};
      4'd9:    res = {1'b1, 6'h02, f_target};
      default: res = {1'b0, 32'h0000_0000};
    endcase
    return res;
  endfunction

  logic [31:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [31:0]       head_r;
  logic              out_valid_r;
  logic [ADDR_W-1:0] addr_r;
  logic [15:0]       word_count_r;
  logic              err_r;

  logic [32:0]       enc_s;
  logic              full_s;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;
  logic [PTR_W-1:0]  rd_ptr_nxt_s;
  logic [PTR_W-1:0]  wr_ptr_nxt_s;
  logic [CNT_W-1:0]  count_nxt_s;
  logic [31:0]       head_nxt_s;

  assign enc_s    = encode(op_sel, rs, rt, rd, imm, target);
  assign full_s   = (count_r == FULL_CNT);
  assign in_ready = !full_s;
  assign accept_s = in_valid && in_ready;
  // clear swallows both handshakes in its cycle
  assign push_s   = accept_s && enc_s[32] && !clear;
  assign pop_s    = out_valid_r && out_ready && !clear;

  assign out_valid  = out_valid_r;
  assign imem_wdata = head_r;
  assign imem_addr  = addr_r;
  assign word_count = word_count_r;
  assign err        = err_r;

  // Next pointers/occupancy and the word that will sit at the head after this edge.
  always_comb begin
    rd_ptr_nxt_s = rd_ptr_r;
    wr_ptr_nxt_s = wr_ptr_r;
    count_nxt_s  = count_r;
    head_nxt_s   = head_r;
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
    // When the new head slot is the one being written this edge, the memory
    // does not hold it yet, so forward the freshly encoded word.
    if (count_nxt_s != CNT_W'(0)) begin
      if (push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
        head_nxt_s = enc_s[31:0];
      end else begin
        head_nxt_s = mem[rd_ptr_nxt_s];
      end
    end else begin
      head_nxt_s = head_r;
    end
  end

  // FIFO storage; only ever read after being written, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem[wr_ptr_r] <= enc_s[31:0];
    end
  end

  // Control state, output registers, address and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      head_r       <= 32'h0000_0000;
      out_valid_r  <= 1'b0;
      addr_r       <= BASE_ADDR;
      word_count_r <= 16'h0000;
      err_r        <= 1'b0;
    end else if (clear) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      out_valid_r  <= 1'b0;
      addr_r       <= BASE_ADDR;
      word_count_r <= 16'h0000;
      err_r        <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      head_r      <= head_nxt_s;
      out_valid_r <= (count_nxt_s != CNT_W'(0));
      if (pop_s) begin
        addr_r <= addr_r + ADDR_STEP;
        if (word_count_r != 16'hFFFF) begin
          word_count_r <= word_count_r + 16'h0001;
        end
      end
      if (accept_s && !enc_s[32]) begin
        err_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
module tb_mips_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op_sel;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] imem_wdata;
  logic [31:0] imem_addr;
  logic [15:0] word_count;
  logic        err;

  // Narrow-address instance sharing the same stimulus, for address wrap.
  logic        in_ready4;
  logic        out_valid4;
  logic [31:0] imem_wdata4;
  logic [3:0]  imem_addr4;
  logic [15:0] word_count4;
  logic        err4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mips_instr_encoder dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .out_valid(out_valid), .out_ready(out_ready),
    .imem_wdata(imem_wdata), .imem_addr(imem_addr),
    .word_count(word_count), .err(err)
  );

  mips_instr_encoder #(.ADDR_W(4)) dut4 (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready4),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .out_valid(out_valid4), .out_ready(out_ready),
    .imem_wdata(imem_wdata4), .imem_addr(imem_addr4),
    .word_count(word_count4), .err(err4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [3:0] o, input logic [4:0] s, input logic [4:0] t,
                     input logic [4:0] d, input logic [15:0] i, input logic [25:0] g);
    in_valid = 1'b1;
    op_sel   = o;
    rs       = s;
    rt       = t;
    rd       = d;
    imm      = i;
    target   = g;
  endtask

  // Stall-test requests: ADD, SUB, AND, OR, SW
  logic [3:0]  s_op  [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6};
  logic [4:0]  s_rs  [5] = '{5'd1, 5'd4, 5'd7, 5'd10, 5'd29};
  logic [4:0]  s_rt  [5] = '{5'd2, 5'd5, 5'd8, 5'd11, 5'd31};
  logic [4:0]  s_rd  [5] = '{5'd3, 5'd6, 5'd9, 5'd12, 5'd0};
  logic [15:0] s_imm [5] = '{16'h1234, 16'h0000, 16'hFFFF, 16'h0000, 16'h8000};
  logic [31:0] s_exp [5] = '{32'h00221820, 32'h00853022, 32'h00E84824,
                             32'h014B6025, 32'hAFBF8000};

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_sel = 4'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; imm = 16'h0; target = 26'h0;
    step();
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_count", {16'd0, word_count}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;
    step();

    // Single ADD into empty FIFO
    out_ready = 1'b1;
    req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    step();
    in_valid = 1'b0;
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_word", imem_wdata, 32'h00221820);
    chk("add_addr", imem_addr, 32'h0);
    step();
    chk("add_drained", {31'd0, out_valid}, 32'd0);
    chk("add_addr_inc", imem_addr, 32'h4);
    chk("add_count", {16'd0, word_count}, 32'd1);
    chk("add_hold", imem_wdata, 32'h00221820);

    // Streamed sequence from a fresh base
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_addr", imem_addr, 32'h0);
    req(4'd5, 5'd29, 5'd8, 5'd31, 16'h0004, 26'h3FFFFFF);
    step();
    chk("seq_lw", imem_wdata, 32'h8FA80004);
    chk("seq_lw_addr", imem_addr, 32'h0);
    req(4'd4, 5'd9, 5'd8, 5'd10, 16'hABCD, 26'h1555555);
    step();
    chk("seq_slt", imem_wdata, 32'h0128502A);
    chk("seq_slt_addr", imem_addr, 32'h4);
    req(4'd7, 5'd4, 5'd5, 5'd7, 16'hFFFF, 26'h0);
    step();
    chk("seq_beq", imem_wdata, 32'h1085FFFF);
    chk("seq_beq_addr", imem_addr, 32'h8);
    req(4'd9, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000010);
    step();
    in_valid = 1'b0;
    chk("seq_j", imem_wdata, 32'h08000010);
    chk("seq_j_addr", imem_addr, 32'hC);
    step();
    chk("seq_done_valid", {31'd0, out_valid}, 32'd0);
    chk("seq_done_addr", imem_addr, 32'h10);
    chk("seq_done_count", {16'd0, word_count}, 32'd4);
    chk("seq_narrow_wrap", {28'd0, imem_addr4}, 32'h0);

    // Back-pressure: fill the FIFO, hold the fifth request, then drain
    clear = 1'b1;
    step();
    clear = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req(s_op[i], s_rs[i], s_rt[i], s_rd[i], s_imm[i], 26'h0);
      chk("fill_in_ready", {31'd0, in_ready}, 32'd1);
      step();
    end
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_head", imem_wdata, s_exp[0]);
    req(s_op[4], s_rs[4], s_rt[4], s_rd[4], s_imm[4], 26'h0);
    step();
    step();
    chk("stall_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_head", imem_wdata, s_exp[0]);
    chk("stall_addr", imem_addr, 32'h0);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    chk("drain1_head", imem_wdata, s_exp[1]);
    chk("drain1_addr", imem_addr, 32'h4);
    chk("drain1_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("drain2_head", imem_wdata, s_exp[2]);
    chk("drain2_addr", imem_addr, 32'h8);
    step();
    chk("drain3_head", imem_wdata, s_exp[3]);
    chk("drain3_addr4", {28'd0, imem_addr4}, 32'hC);
    step();
    chk("drain4_head", imem_wdata, s_exp[4]);
    chk("drain4_addr", imem_addr, 32'h10);
    chk("drain4_addr4_wrap", {28'd0, imem_addr4}, 32'h0);
    step();
    chk("drain_empty", {31'd0, out_valid}, 32'd0);
    chk("drain_count", {16'd0, word_count}, 32'd5);
    chk("drain_hold", imem_wdata, s_exp[4]);

    // Illegal selector
    req(4'd12, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
    chk("ill_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_no_valid", {31'd0, out_valid}, 32'd0);
    req(4'd8, 5'd2, 5'd3, 5'd9, 16'h0010, 26'h0);
    step();
    in_valid = 1'b0;
    chk("ill_bne", imem_wdata, 32'h14430010);
    chk("ill_err_sticky", {31'd0, err}, 32'd1);
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("ill_err_clear", {31'd0, err}, 32'd0);

    // Clear with queued words and a concurrent request
    out_ready = 1'b1;
    req(s_op[0], s_rs[0], s_rt[0], s_rd[0], s_imm[0], 26'h0);
    step();
    req(s_op[1], s_rs[1], s_rt[1], s_rd[1], s_imm[1], 26'h0);
    step();
    out_ready = 1'b0;
    req(s_op[2], s_rs[2], s_rt[2], s_rd[2], s_imm[2], 26'h0);
    step();
    req(s_op[3], s_rs[3], s_rt[3], s_rd[3], s_imm[3], 26'h0);
    step();
    chk("preclr_count", {16'd0, word_count}, 32'd1);
    chk("preclr_addr", imem_addr, 32'h4);
    req(s_op[0], s_rs[0], s_rt[0], s_rd[0], s_imm[0], 26'h0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clr_valid", {31'd0, out_valid}, 32'd0);
    chk("clr_addr_base", imem_addr, 32'h0);
    chk("clr_count", {16'd0, word_count}, 32'd0);
    chk("clr_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("clr_not_captured", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset in the middle of a burst
    out_ready = 1'b1;
    req(4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    step();
    req(s_op[0], s_rs[0], s_rt[0], s_rd[0], s_imm[0], 26'h0);
    step();
    req(s_op[1], s_rs[1], s_rt[1], s_rd[1], s_imm[1], 26'h0);
    step();
    chk("burst_valid", {31'd0, out_valid}, 32'd1);
    chk("burst_err", {31'd0, err}, 32'd1);
    chk("burst_count", {16'd0, word_count}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_wdata", imem_wdata, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_count", {16'd0, word_count}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    in_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
